// File: rtl/adder_pipe_nbit.sv
// Pipelined unsigned adder: one CHUNK_BITS slice per stage with a valid/ready handshake.
// Define ADDER_SATURATE_EN to clamp the sum to all ones on a final carry instead of wrapping.
module adder_pipe_nbit #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    localparam int STAGES = NUM_BITS / CHUNK_BITS;

    logic              adv;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_carry;

    // One global enable: the whole pipe stalls together, bubbles included.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = stage_valid[STAGES-1];
    assign overflow  = stage_carry[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int DONE_W = (k + 1) * CHUNK_BITS;
        localparam int REST_W = NUM_BITS - DONE_W;

        logic [CHUNK_BITS-1:0] a_chunk;
        logic [CHUNK_BITS-1:0] b_chunk;
        logic                  c_prev;
        logic                  v_prev;
        logic [CHUNK_BITS:0]   chunk_sum;
        logic [DONE_W-1:0]     sum_wrap;
        logic [DONE_W-1:0]     sum_next;
        logic [DONE_W-1:0]     sum_q;
        logic                  valid_q;
        logic                  carry_q;

        if (k == 0) begin : g_first
            assign a_chunk  = a[CHUNK_BITS-1:0];
            assign b_chunk  = b[CHUNK_BITS-1:0];
            assign c_prev   = carry_in;
            assign v_prev   = in_valid;
            assign sum_wrap = chunk_sum[CHUNK_BITS-1:0];
        end else begin : g_next
            assign a_chunk  = g_stage[k-1].g_ops.a_q[CHUNK_BITS-1:0];
            assign b_chunk  = g_stage[k-1].g_ops.b_q[CHUNK_BITS-1:0];
            assign c_prev   = stage_carry[k-1];
            assign v_prev   = stage_valid[k-1];
            assign sum_wrap = {chunk_sum[CHUNK_BITS-1:0], g_stage[k-1].sum_q};
        end

        assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK_BITS{1'b0}}, c_prev};

        if (k == STAGES - 1) begin : g_last
`ifdef ADDER_SATURATE_EN
            assign sum_next = chunk_sum[CHUNK_BITS] ? '1 : sum_wrap;
`else
            assign sum_next = sum_wrap;
`endif
            assign sum = sum_q;
        end else begin : g_mid
            assign sum_next = sum_wrap;
        end

        // NOTE: data registers are reset too, so sum/overflow read 0 after reset, not stale values.
        always_ff @(posedge clk) begin
            if (!n_rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= v_prev;
                carry_q <= chunk_sum[CHUNK_BITS];
                sum_q   <= sum_next;
            end
        end

        assign stage_valid[k] = valid_q;
        assign stage_carry[k] = carry_q;

        // Skew registers: operand chunks not yet added, right-justified.
        if (k < STAGES - 1) begin : g_ops
            logic [REST_W-1:0] a_q;
            logic [REST_W-1:0] b_q;
            logic [REST_W-1:0] a_next;
            logic [REST_W-1:0] b_next;

            if (k == 0) begin : g_src_in
                assign a_next = a[NUM_BITS-1:CHUNK_BITS];
                assign b_next = b[NUM_BITS-1:CHUNK_BITS];
            end else begin : g_src_prev
                assign a_next = g_stage[k-1].g_ops.a_q[REST_W+CHUNK_BITS-1:CHUNK_BITS];
                assign b_next = g_stage[k-1].g_ops.b_q[REST_W+CHUNK_BITS-1:CHUNK_BITS];
            end

            always_ff @(posedge clk) begin
                if (!n_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_next;
                    b_q <= b_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit (16/4) plus an exhaustive sweep of a 4/1 instance.
// Expectations follow ADDER_SATURATE_EN when the bench is built with it.
module tb_adder_pipe_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic        in_valid, in_ready, out_valid, out_ready, carry_in, overflow;
    logic [15:0] a, b, sum;

    logic        in_valid_s, in_ready_s, out_valid_s, out_ready_s, carry_in_s, overflow_s;
    logic [3:0]  a_s, b_s, sum_s;

    int n_cmp = 0;
    int n_err = 0;

    adder_pipe_nbit #(.NUM_BITS(16), .CHUNK_BITS(4)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .overflow(overflow)
    );

    adder_pipe_nbit #(.NUM_BITS(4), .CHUNK_BITS(1)) dut_small (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .a(a_s), .b(b_s), .carry_in(carry_in_s), .out_valid(out_valid_s),
        .out_ready(out_ready_s), .sum(sum_s), .overflow(overflow_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] av, input logic [15:0] bv, input logic c);
        in_valid = v;
        a        = av;
        b        = bv;
        carry_in = c;
    endtask

    // raw is the hand-computed 17-bit {carry, sum}; saturation only changes the sum bits.
    function automatic logic [16:0] exp16(input logic [16:0] raw);
`ifdef ADDER_SATURATE_EN
        return raw[16] ? 17'h1FFFF : raw;
`else
        return raw;
`endif
    endfunction

    function automatic logic [4:0] exp5(input logic [4:0] raw);
`ifdef ADDER_SATURATE_EN
        return raw[4] ? 5'h1F : raw;
`else
        return raw;
`endif
    endfunction

    logic [4:0] small_q[$];
    int         small_got;
    logic [16:0] held;

    initial begin
        n_rst       = 1'b0;
        out_ready   = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        in_valid_s  = 1'b0;
        a_s         = 4'h0;
        b_s         = 4'h0;
        carry_in_s  = 1'b0;
        out_ready_s = 1'b1;
        step();
        step();

        // Reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_overflow", overflow, 0);
        check("rst_in_ready", in_ready, 1);

        n_rst     = 1'b1;
        out_ready = 1'b1;

        // Basic add, latency 4
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        check("basic_not_early", out_valid, 0);
        step();
        check("basic_valid", out_valid, 1);
        check("basic_result", {overflow, sum}, exp16(17'h02345));
        step();

        // Full carry ripple across every chunk
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        step();
        check("ripple_valid", out_valid, 1);
        check("ripple_result", {overflow, sum}, exp16(17'h10000));
        step();

        // Streaming: four back-to-back operands
        drive(1'b1, 16'h0001, 16'h0001, 1'b0); step();
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0); step();
        drive(1'b1, 16'h8000, 16'h8000, 1'b0); step();
        drive(1'b1, 16'h7FFF, 16'h0000, 1'b1); step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("stream0_valid", out_valid, 1);
        check("stream0", {overflow, sum}, exp16(17'h00002));
        step();
        check("stream1_valid", out_valid, 1);
        check("stream1", {overflow, sum}, exp16(17'h00100));
        step();
        check("stream2_valid", out_valid, 1);
        check("stream2", {overflow, sum}, exp16(17'h10000));
        step();
        check("stream3_valid", out_valid, 1);
        check("stream3", {overflow, sum}, exp16(17'h08000));
        step();
        check("stream_drained", out_valid, 0);

        // Backpressure with a second operand in flight
        out_ready = 1'b0;
        drive(1'b1, 16'h0101, 16'h0202, 1'b0); step();
        drive(1'b1, 16'h1000, 16'h0F00, 1'b1); step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        check("bp_valid", out_valid, 1);
        check("bp_first", {overflow, sum}, exp16(17'h00303));
        check("bp_in_ready", in_ready, 0);
        held = {overflow, sum};
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_sum", {overflow, sum}, held);
            check("bp_hold_in_ready", in_ready, 0);
        end

        // Release and accept a new operand in the same cycle
        out_ready = 1'b1;
        drive(1'b1, 16'h0001, 16'h0002, 1'b0);
        #1;
        check("acc_full_in_ready", in_ready, 1);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("bp_second_valid", out_valid, 1);
        check("bp_second", {overflow, sum}, exp16(17'h01F01));
        step();
        check("bp_no_dup", out_valid, 0);
        step();
        step();
        check("acc_full_valid", out_valid, 1);
        check("acc_full_result", {overflow, sum}, exp16(17'h00003));
        step();

        // Reset mid-flight with three operands in the pipe
        drive(1'b1, 16'h0001, 16'h0001, 1'b0); step();
        drive(1'b1, 16'h0002, 16'h0002, 1'b0); step();
        drive(1'b1, 16'h0003, 16'h0003, 1'b0); step();
        n_rst = 1'b0;
        drive(1'b1, 16'h5555, 16'h5555, 1'b0);
        step();
        n_rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_sum", {overflow, sum}, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_mid_quiet", out_valid, 0);
        end
        drive(1'b1, 16'h0ABC, 16'h0123, 1'b0);
        step();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
        step();
        step();
        check("post_rst_not_early", out_valid, 0);
        step();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_result", {overflow, sum}, exp16(17'h00BDF));
        step();

        // Exhaustive 4-bit / 1-bit-chunk sweep
        small_got = 0;
        for (int i = 0; i < 512 + 8; i++) begin
            if (i < 512) begin
                logic [3:0] av;
                logic [3:0] bv;
                logic       cv;
                av = i[3:0];
                bv = i[7:4];
                cv = i[8];
                in_valid_s = 1'b1;
                a_s        = av;
                b_s        = bv;
                carry_in_s = cv;
                small_q.push_back(exp5({1'b0, av} + {1'b0, bv} + {4'b0, cv}));
            end else begin
                in_valid_s = 1'b0;
            end
            step();
            if (out_valid_s) begin
                small_got++;
                if (small_q.size() == 0) check("small_extra", 1, 0);
                else check("small_result", {overflow_s, sum_s}, small_q.pop_front());
            end
        end
        check("small_count", small_got, 512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
